// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM handshake state, word type and arbiter FSM/owner encodings.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    // Latched RAM transaction held for the whole grant, including retries.
    typedef struct packed {
        logic  wen;
        word_t addr;
        word_t store;
    } ram_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for instruction and data requesters with retry on ERROR.
// Optional MEM_ARB_PERF_EN adds icount/dcount/stallcount performance counters.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 3,
    parameter word_t       ERR_WORD  = 32'hBAD1BAD1
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      err,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
`ifdef MEM_ARB_PERF_EN
    ,
    output word_t     icount,
    output word_t     dcount,
    output word_t     stallcount
`endif
);

    localparam int unsigned CNT_W = 4;

    arb_state_t       state, state_n;
    arb_owner_t       owner, owner_n;
    logic             token, token_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    ram_req_t         req, req_n;
    logic             ren_n, wen_n;
    word_t            iload_n, dload_n;
    logic             err_n;
    logic             owner_live;

    assign iwait = iREN && !(state == RESP && owner == OWN_I);
    assign dwait = (dREN || dWEN) && !(state == RESP && owner == OWN_D);

    assign ramaddr  = req.addr;
    assign ramstore = req.store;

    // A requester that let go mid-transaction gets its response discarded.
    assign owner_live = (owner == OWN_I) ? iREN : (dREN || dWEN);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state  <= IDLE;
            owner  <= OWN_I;
            token  <= 1'b0;
            cnt    <= '0;
            req    <= '0;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            iload  <= '0;
            dload  <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            token  <= token_n;
            cnt    <= cnt_n;
            req    <= req_n;
            ramREN <= ren_n;
            ramWEN <= wen_n;
            iload  <= iload_n;
            dload  <= dload_n;
            err    <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        token_n = token;
        cnt_n   = cnt;
        req_n   = req;
        ren_n   = ramREN;
        wen_n   = ramWEN;
        iload_n = iload;
        dload_n = dload;
        err_n   = 1'b0;

        case (state)
            IDLE: begin
                // Data wins unless a fetch is waiting and data was served last.
                if ((dREN || dWEN) && !(token && iREN)) begin
                    owner_n     = OWN_D;
                    token_n     = 1'b1;
                    req_n.wen   = dWEN;
                    req_n.addr  = daddr;
                    req_n.store = dstore;
                    ren_n       = !dWEN;
                    wen_n       = dWEN;
                    state_n     = GRANT;
                end else if (iREN) begin
                    owner_n     = OWN_I;
                    token_n     = 1'b0;
                    req_n.wen   = 1'b0;
                    req_n.addr  = iaddr;
                    req_n.store = '0;
                    ren_n       = 1'b1;
                    wen_n       = 1'b0;
                    state_n     = GRANT;
                end
            end

            GRANT: begin
                if (!ramREN && !ramWEN) begin
                    // Strobes were dropped for one cycle after ERROR; re-issue.
                    ren_n = !req.wen;
                    wen_n = req.wen;
                end else begin
                    case (ramstate)
                        ACCESS: begin
                            ren_n   = 1'b0;
                            wen_n   = 1'b0;
                            state_n = RESP;
                            if (!req.wen && owner_live) begin
                                if (owner == OWN_I) iload_n = ramload;
                                else                dload_n = ramload;
                            end
                        end
                        ERROR: begin
                            ren_n = 1'b0;
                            wen_n = 1'b0;
                            cnt_n = cnt + CNT_W'(1);
                            if (cnt_n == CNT_W'(MAX_RETRY)) begin
                                state_n = RESP;
                                err_n   = owner_live;
                                if (!req.wen && owner_live) begin
                                    if (owner == OWN_I) iload_n = ERR_WORD;
                                    else                dload_n = ERR_WORD;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end

            RESP: begin
                cnt_n   = '0;
                state_n = IDLE;
            end

            default: state_n = IDLE;
        endcase
    end

`ifdef MEM_ARB_PERF_EN
    // Completed transactions per side and cycles spent waiting on the RAM.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            icount     <= '0;
            dcount     <= '0;
            stallcount <= '0;
        end else begin
            if (state == RESP) begin
                if (owner == OWN_I) icount <= icount + 32'(1);
                else                dcount <= dcount + 32'(1);
            end
            if (state == GRANT) stallcount <= stallcount + 32'(1);
        end
    end
`endif

endmodule
